// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
// Shared definitions for the UART transmit scheduler: register indices,
// STATUS/CTRL bit positions and the launch sequencer state encoding.
// Ports: none (package).
package uart_tx_sched_pkg;

  // Register indices on the IO page
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_ACTIVE  = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_IRQ     = 4;
  localparam int ST_CNT_LSB = 8;

  // CTRL bit positions
  localparam int CT_EN      = 0;
  localparam int CT_FLUSH   = 1;
  localparam int CT_CLR_OVF = 2;
  localparam int CT_IRQ_EN  = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
// Bundles the CPU IO-page access signals and the UART TX core handshake.
//   slave  : the scheduler (receives io_* and tx_busy, drives io_rdata,
//            tx_start, tx_data and, with UART_TX_SCHED_IRQ_EN, irq)
//   master : the SOC side / TX core (opposite directions)
// Optional macro: UART_TX_SCHED_IRQ_EN adds the irq signal.
interface uart_tx_sched_if;
  logic        io_sel;
  logic [1:0]  io_addr;
  logic        io_wr;
  logic        io_rd;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
`ifdef UART_TX_SCHED_IRQ_EN
  logic        irq;
`endif

  modport slave (
`ifdef UART_TX_SCHED_IRQ_EN
    output irq,
`endif
    input  io_sel, io_addr, io_wr, io_rd, io_wdata, tx_busy,
    output io_rdata, tx_start, tx_data
  );

  modport master (
`ifdef UART_TX_SCHED_IRQ_EN
    input  irq,
`endif
    output io_sel, io_addr, io_wr, io_rd, io_wdata, tx_busy,
    input  io_rdata, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_sched_sync_fifo.sv
// sync_fifo
// DEPTH x 8 register-file FIFO with combinational head output.
// Ports: clk, rst (sync, active-high), push, pop, flush, din[7:0],
//        dout[7:0] (head), count[AW:0], full, empty.
// Push on full and pop on empty are ignored; flush has priority over both.
module sync_fifo #(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == (AW+1)'(0));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next pointer/count values; full test uses the pre-pop count
  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Memory-mapped UART transmit scheduler. CPU byte writes to DATA are queued
// in a FIFO and handed to the UART TX core one at a time via a start/busy
// handshake, so firmware never polls TX busy.
// Ports: CLK, RESET (sync, active-high), bus (uart_tx_sched_if.slave):
//   io_sel/io_addr/io_wr/io_rd/io_wdata in, io_rdata out (registered),
//   tx_start/tx_data out (registered), tx_busy in.
// Optional macro: UART_TX_SCHED_IRQ_EN adds bus.irq, CTRL bit3 irq_en and
//   STATUS bit4 (irq mirror). Without it those bits read 0.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic           CLK,
  input logic           RESET,
  uart_tx_sched_if.slave bus
);

  tx_state_e   state_q, state_d;
  logic        enable_q, enable_d;
  logic        ovf_q, ovf_d;
  logic [31:0] io_rdata_q, io_rdata_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic        data_wr_s, ctrl_wr_s, rd_s, flush_s, pop_s;
  logic [7:0]  fifo_dout_s;
  logic [AW:0] fifo_count_s;
  logic        fifo_full_s, fifo_empty_s;
  logic        irq_en_s, irq_s;
  logic [31:0] status_s, ctrl_s;
  logic        wdata_unused;

  assign data_wr_s = bus.io_sel & bus.io_wr & (bus.io_addr == REG_DATA);
  assign ctrl_wr_s = bus.io_sel & bus.io_wr & (bus.io_addr == REG_CTRL);
  assign rd_s      = bus.io_sel & bus.io_rd;
  assign flush_s   = ctrl_wr_s & bus.io_wdata[CT_FLUSH];
  // The head byte is captured into tx_data on entry to LAUNCH and popped here
  assign pop_s     = (state_q == LAUNCH);
  assign wdata_unused = ^bus.io_wdata[31:8];

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (data_wr_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   (bus.io_wdata[7:0]),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

`ifdef UART_TX_SCHED_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;

  // irq fires once everything queued has been handed off and completed
  always_comb begin
    irq_en_d = ctrl_wr_s ? bus.io_wdata[CT_IRQ_EN] : irq_en_q;
    irq_d    = irq_en_q & fifo_empty_s & (state_q == IDLE);
  end

  // Interrupt enable and registered interrupt output
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.irq  = irq_q;
  assign irq_en_s = irq_en_q;
  assign irq_s    = irq_q;
`else
  assign irq_en_s = 1'b0;
  assign irq_s    = 1'b0;
`endif

  // Read-back views of STATUS and CTRL
  always_comb begin
    status_s                      = 32'd0;
    status_s[ST_FULL]             = fifo_full_s;
    status_s[ST_EMPTY]            = fifo_empty_s;
    status_s[ST_ACTIVE]           = (state_q != IDLE);
    status_s[ST_OVF]              = ovf_q;
    status_s[ST_IRQ]              = irq_s;
    status_s[ST_CNT_LSB +: 8]     = 8'(fifo_count_s);
    ctrl_s                        = 32'd0;
    ctrl_s[CT_EN]                 = enable_q;
    ctrl_s[CT_IRQ_EN]             = irq_en_s;
  end

  // Register file: enable, sticky overflow, read data (held between reads)
  always_comb begin
    enable_d   = ctrl_wr_s ? bus.io_wdata[CT_EN] : enable_q;
    ovf_d      = ovf_q;
    io_rdata_d = io_rdata_q;
    if (ctrl_wr_s && bus.io_wdata[CT_CLR_OVF]) begin
      ovf_d = 1'b0;
    end else if (data_wr_s && fifo_full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    if (rd_s) begin
      case (bus.io_addr)
        REG_DATA, REG_STATUS: io_rdata_d = status_s;
        REG_CTRL:             io_rdata_d = ctrl_s;
        default:              io_rdata_d = 32'd0;
      endcase
    end else begin
      io_rdata_d = io_rdata_q;
    end
  end

  // Launch sequencer; tx_start/tx_data are registered so they align with LAUNCH
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (enable_q && !fifo_empty_s && !bus.tx_busy) begin
          state_d    = LAUNCH;
          tx_start_d = 1'b1;
          tx_data_d  = fifo_dout_s;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH:    state_d = WAIT_ACK;
      WAIT_ACK:  state_d = bus.tx_busy ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: state_d = bus.tx_busy ? WAIT_DONE : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      enable_q   <= 1'b1;
      ovf_q      <= 1'b0;
      io_rdata_q <= 32'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      ovf_q      <= ovf_d;
      io_rdata_q <= io_rdata_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.io_rdata = io_rdata_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (DEPTH=8) with a TX-core model that
// holds busy for 20 cycles per byte (optionally after an ack delay).
module tb_uart_tx_sched;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  uart_tx_sched_if bus();

  uart_tx_sched #(.DEPTH(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_fall_cyc = -1;
  int   ack_delay = 0;
  bit   gap_en = 1'b0;
  bit   stab_en = 1'b1;
  logic [7:0] sent_q[$];
  logic [7:0] last_data;
  logic       start_prev;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[18];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] addr, input logic [31:0] data);
    bus.io_sel = 1'b1; bus.io_wr = 1'b1; bus.io_addr = addr; bus.io_wdata = data;
    @(posedge CLK); #1;
    bus.io_sel = 1'b0; bus.io_wr = 1'b0; bus.io_wdata = 32'd0;
  endtask

  task automatic bus_rd(input logic [1:0] addr, output logic [31:0] data);
    bus.io_sel = 1'b1; bus.io_rd = 1'b1; bus.io_addr = addr;
    @(posedge CLK); #1;
    bus.io_sel = 1'b0; bus.io_rd = 1'b0;
    data = bus.io_rdata;
  endtask

  task automatic rd_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(addr, d);
    check(name, d, exp);
  endtask

  // Wait until `target` bytes have launched and the TX core is idle again
  task automatic wait_sent(input int target, input int max_cyc, input string name);
    int k;
    k = 0;
    while (!(sent_q.size() >= target && bus.tx_busy == 1'b0) && k < max_cyc) begin
      @(negedge CLK);
      k++;
    end
    checks++;
    if (k >= max_cyc) begin
      failures++;
      $display("FAIL %s timeout: sent=%0d required=%0d", name, sent_q.size(), target);
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // TX core model
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (bus.tx_start === 1'b1) begin
        if (ack_delay > 0) begin
          repeat (ack_delay) @(posedge CLK);
          #1;
        end
        bus.tx_busy = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        bus.tx_busy = 1'b0;
        last_fall_cyc = cyc;
      end
    end
  end

  // Launch monitor: pulse width, launch gap, data stability while busy
  initial begin
    start_prev = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (bus.tx_start === 1'b1) begin
        checks++;
        if (start_prev) begin
          failures++;
          $display("FAIL start_width actual=2+ cycles required=1 cycle");
        end else begin
          sent_q.push_back(bus.tx_data);
          last_data = bus.tx_data;
          if (gap_en && last_fall_cyc >= 0) begin
            check("launch_gap", cyc - last_fall_cyc, 32'd2);
          end
        end
      end
      if (stab_en && bus.tx_busy === 1'b1) begin
        check("tx_data_stable", {24'd0, bus.tx_data}, {24'd0, last_data});
      end
      start_prev = (bus.tx_start === 1'b1);
    end
  end

  initial begin
    int base;
    logic [7:0] b;
    int k;

    bus.io_sel = 1'b0; bus.io_wr = 1'b0; bus.io_rd = 1'b0;
    bus.io_addr = 2'd0; bus.io_wdata = 32'd0;

    // Table for the overflow / register access scenario
    tbl[0] = '{1'b1, 2'd2, 32'h0, 32'h0};
    for (int i = 0; i < 9; i++) tbl[1+i] = '{1'b1, 2'd0, 32'h50 + 32'(i), 32'h0};
    tbl[10] = '{1'b0, 2'd1, 32'h0, 32'h0000_0809};
    tbl[11] = '{1'b0, 2'd2, 32'h0, 32'h0000_0000};
    tbl[12] = '{1'b1, 2'd2, 32'h4, 32'h0};
    tbl[13] = '{1'b0, 2'd1, 32'h0, 32'h0000_0801};
    tbl[14] = '{1'b1, 2'd1, 32'hFF, 32'h0};
    tbl[15] = '{1'b1, 2'd3, 32'hFF, 32'h0};
    tbl[16] = '{1'b0, 2'd0, 32'h0, 32'h0000_0801};
    tbl[17] = '{1'b0, 2'd3, 32'h0, 32'h0000_0000};

    // Reset
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("rst_rdata", bus.io_rdata, 32'd0);
    check("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
`ifdef UART_TX_SCHED_IRQ_EN
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
`endif
    rd_check("rst_status", 2'd1, 32'h0000_0002);
    rd_check("rst_ctrl", 2'd2, 32'h0000_0001);

    // Three back-to-back bytes
    last_fall_cyc = -1;
    gap_en = 1'b1;
    bus_wr(2'd0, 32'h41);
    bus_wr(2'd0, 32'h42);
    bus_wr(2'd0, 32'h43);
    wait_sent(3, 300, "t1_drain");
    gap_en = 1'b0;
    check("t1_count", sent_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      b = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
      check($sformatf("t1_byte%0d", i), {24'd0, b}, 32'h41 + 32'(i));
    end
    rd_check("t1_status", 2'd1, 32'h0000_0002);

    // Overflow with enable cleared, register access table
    base = sent_q.size();
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].wr) bus_wr(tbl[i].addr, tbl[i].wdata);
      else rd_check($sformatf("t2_vec%0d", i), tbl[i].addr, tbl[i].exp);
    end
    // Push on full in the same cycle as the launch pop
    bus_wr(2'd2, 32'h1);
    @(posedge CLK); #1;
    check("t2_launch", {31'd0, bus.tx_start}, 32'd1);
    bus_wr(2'd0, 32'h99);
    rd_check("t2_collide_status", 2'd1, 32'h0000_070C);
    wait_sent(base + 8, 800, "t2_drain");
    check("t2_count", sent_q.size() - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      b = (base + i < sent_q.size()) ? sent_q[base+i] : 8'hxx;
      check($sformatf("t2_byte%0d", i), {24'd0, b}, 32'h50 + 32'(i));
    end
    rd_check("t2_status_drained", 2'd1, 32'h0000_000A);
    bus_wr(2'd2, 32'h5);
    rd_check("t2_status_clr", 2'd1, 32'h0000_0002);

    // Flush while the first of four bytes is in flight
    base = sent_q.size();
    bus_wr(2'd0, 32'h61);
    bus_wr(2'd0, 32'h62);
    bus_wr(2'd0, 32'h63);
    bus_wr(2'd0, 32'h64);
    repeat (3) @(posedge CLK);
    #1;
    bus_wr(2'd2, 32'h3);
    rd_check("t3_status_flushed", 2'd1, 32'h0000_0006);
    wait_sent(base + 1, 200, "t3_drain");
    repeat (40) @(posedge CLK);
    #1;
    check("t3_count", sent_q.size() - base, 32'd1);
    b = (base < sent_q.size()) ? sent_q[base] : 8'hxx;
    check("t3_byte", {24'd0, b}, 32'h61);
    rd_check("t3_status", 2'd1, 32'h0000_0002);

    // Reset while waiting for the TX core to acknowledge
    base = sent_q.size();
    ack_delay = 6;
    stab_en = 1'b0;
    bus_wr(2'd0, 32'h71);
    bus_wr(2'd0, 32'h72);
    bus_wr(2'd2, 32'h0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("t4_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("t4_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("t4_rdata", bus.io_rdata, 32'd0);
    rd_check("t4_status", 2'd1, 32'h0000_0002);
    rd_check("t4_ctrl", 2'd2, 32'h0000_0001);
    wait_sent(base + 1, 200, "t4_drain");
    repeat (30) @(posedge CLK);
    #1;
    check("t4_count", sent_q.size() - base, 32'd1);
    ack_delay = 0;
    stab_en = 1'b1;

    // Interrupt on queue drained
    bus_wr(2'd2, 32'h9);
`ifdef UART_TX_SCHED_IRQ_EN
    rd_check("t5_ctrl", 2'd2, 32'h0000_0009);
    rd_check("t5_status", 2'd1, 32'h0000_0012);
    check("t5_irq_idle", {31'd0, bus.irq}, 32'd1);
    base = sent_q.size();
    bus_wr(2'd0, 32'h81);
    bus_wr(2'd0, 32'h82);
    check("t5_irq_active", {31'd0, bus.irq}, 32'd0);
    k = 0;
    while (sent_q.size() < base + 2 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("t5_second_start", sent_q.size() - base, 32'd2);
    check("t5_irq_busy", {31'd0, bus.irq}, 32'd0);
    k = 0;
    while (bus.tx_busy == 1'b1 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check("t5_busy_fall", {31'd0, bus.tx_busy}, 32'd0);
    check("t5_irq_wait_done", {31'd0, bus.irq}, 32'd0);
    @(posedge CLK); #1;
    check("t5_irq_at_idle", {31'd0, bus.irq}, 32'd0);
    @(posedge CLK); #1;
    check("t5_irq_rise", {31'd0, bus.irq}, 32'd1);
`else
    rd_check("t5_ctrl", 2'd2, 32'h0000_0001);
    rd_check("t5_status", 2'd1, 32'h0000_0002);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout actual=time limit reached required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Memory-mapped UART transmit scheduler for the SOC IO page.
- Accepts byte writes from the CPU and buffers them in a small FIFO.
- Sequences the existing UART transmitter (start/busy handshake) one byte at a time so firmware never polls TX busy.
- Sits between the SOC IO decode and the UART TX core that drives TXD.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- AW, $clog2(DEPTH), FIFO pointer width (derived; do not override).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- io_sel  in  1  IO access targets this block
- io_addr  in  2  register index: 0 DATA, 1 STATUS, 2 CTRL
- io_wr  in  1  write strobe (one cycle)
- io_rd  in  1  read strobe (one cycle)
- io_wdata  in  32  write data
- io_rdata  out  32  read data, registered
- tx_start  out  1  one-cycle launch pulse to the UART TX core
- tx_data  out  8  byte to send; stable from tx_start until tx_busy falls
- tx_busy  in  1  UART TX core busy

Behaviour:
- Reset: io_rdata=0, tx_start=0, tx_data=0, FIFO empty, overflow=0, enable=1, FSM=IDLE.
- Reset mid-transmission: aborts sequencing only. The in-flight byte is owned by the TX core.
- DATA write (io_sel&io_wr&addr0): push io_wdata[7:0] if count<DEPTH.
  - If full, the byte is dropped and overflow is set (sticky).
  - The full test uses the pre-pop count, so a push on a full FIFO is rejected even when a pop happens in the same cycle.
- CTRL write: bit0 sets enable. Bit1=1 flushes (pointers and count to 0 next cycle). Bit2=1 clears overflow.
  - Flush does not affect a byte already launched.
  - A flush in the same cycle as a launch-pop wins; the count ends at 0.
- Reads: io_rdata is valid the cycle after io_rd and holds until the next read.
  - addr0 and addr1 return STATUS: bit0 full, bit1 empty, bit2 tx active (FSM != IDLE), bit3 overflow, bits[15:8] count.
  - addr2 returns CTRL: bit0 enable.
  - addr3 returns 0.
  - Writes to addr1 and addr3 are ignored.
- FSM:
  - IDLE -> LAUNCH when enable & !empty & !tx_busy.
  - LAUNCH (1 cycle): tx_start=1, tx_data=head, pop. Then -> WAIT_ACK.
  - WAIT_ACK: stay until tx_busy=1, then -> WAIT_DONE.
  - WAIT_DONE: stay until tx_busy=0, then -> IDLE.
- Back-to-back throughput: one byte per (UART frame + 2 cycles). Minimum gap is IDLE plus LAUNCH.
- Clearing enable stops new launches only. The current byte completes through WAIT_DONE.
- Pointers wrap modulo DEPTH. Count is AW+1 bits and ranges 0..DEPTH.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.

Optional Feature:
- UART_TX_SCHED_IRQ_EN:
  - Adds output irq (1 bit) and CTRL bit3 irq_en (reset 0).
  - irq is registered and equals irq_en & empty & FSM==IDLE, i.e. all queued bytes sent.
  - STATUS bit4 mirrors irq.
- Without the macro: no irq port, CTRL bit3 and STATUS bit4 read 0.

Decomposition:
- Package uart_tx_sched_pkg:
  - register index constants (REG_DATA, REG_STATUS, REG_CTRL)
  - STATUS/CTRL bit-position constants
  - FSM state typedef (IDLE, LAUNCH, WAIT_ACK, WAIT_DONE)
- Sub-module sync_fifo: parameterised DEPTH x 8 register-file FIFO.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Combinational head output.
  - Reused by the future RX path.

Test Plan:
- Reset, then write DATA 0x41, 0x42, 0x43 with a TX-core model holding busy for 20 cycles per byte -> three tx_start pulses with tx_data 0x41, 0x42, 0x43 in order, each pulse 1 cycle, each pulse two cycles after the prior busy fall; STATUS reads empty=1, count=0 at the end.
- Clear enable, write 9 bytes with DEPTH=8 -> STATUS full=1, overflow=1, count=8; the 9th byte is never transmitted; CTRL bit2 write clears overflow.
- Fill 4 bytes, let the first launch, write CTRL flush while in WAIT_DONE -> the in-flight byte completes, no further tx_start, count=0.
- Push on full in the same cycle as a LAUNCH pop -> push rejected, overflow=1, count=7 after the cycle.
- Assert RESET for 1 cycle while in WAIT_ACK -> next cycle FSM=IDLE, tx_start=0, FIFO empty, io_rdata=0, enable=1.
- With UART_TX_SCHED_IRQ_EN and irq_en=1, send 2 bytes -> irq=0 while active and rises one cycle after FSM returns to IDLE with the FIFO empty.
